// File: rtl/ss_cdb_arbiter_rr.sv
// Multi-lane CDB arbiter: round-robin within the ALU/CMP and MULT classes, MULT class
// priority with an ALU/CMP anti-starvation override, and a one-cycle registered broadcast.

package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } rvfi_data_t;

  typedef struct packed {
    logic [5:0]  pd_s;
    logic [4:0]  rob_num;
    logic [31:0] pd_v;
    rvfi_data_t  rvfi_data;
    logic        br_en;
    logic [31:0] br_target;
  } fu_cdb_data_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pd_s;
    logic [4:0]  rob_num;
    logic [31:0] pd_v;
    rvfi_data_t  rvfi_data;
    logic        br_en;
    logic [31:0] branch_pc;
  } cdb_t;

endpackage

module ss_cdb_arbiter_rr
  import rv32i_types::*;
#(
  parameter int unsigned N_ALU_CMP    = 4,
  parameter int unsigned N_MULT       = 2,
  parameter int unsigned N_CDB        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic         [N_ALU_CMP-1:0]  alu_cmp_done,
  input  fu_cdb_data_t [N_ALU_CMP-1:0]  alu_cmp_output_data,
  input  logic         [N_MULT-1:0]     mult_done,
  input  fu_cdb_data_t [N_MULT-1:0]     mult_output_data,
  output logic         [N_ALU_CMP-1:0]  alu_cmp_ack,
  output logic         [N_MULT-1:0]     mult_ack,
  output cdb_t         [N_CDB-1:0]      cdb
);

  localparam int unsigned AW = (N_ALU_CMP > 1) ? $clog2(N_ALU_CMP) : 1;
  localparam int unsigned MW = (N_MULT > 1) ? $clog2(N_MULT) : 1;
  localparam int unsigned LW = (N_CDB > 1) ? $clog2(N_CDB) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] alu_ptr, alu_ptr_nxt;
  logic [MW-1:0] mult_ptr, mult_ptr_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          alu_pri;

  logic [N_ALU_CMP-1:0] alu_ack_c;
  logic [N_MULT-1:0]    mult_ack_c;
  cdb_t [N_CDB-1:0]     lane_nxt;

  int unsigned used;
  int unsigned idx;

  function automatic cdb_t from_fu(fu_cdb_data_t d, logic is_alu);
    cdb_t c;
    c           = '0;
    c.valid     = 1'b1;
    c.pd_s      = d.pd_s;
    c.rob_num   = d.rob_num;
    c.pd_v      = d.pd_v;
    c.rvfi_data = d.rvfi_data;
    if (is_alu) begin
      c.br_en     = d.br_en;
      c.branch_pc = d.br_target;
    end
    return c;
  endfunction

  // Two passes: pass 0 serves the priority class, pass 1 the other; lanes fill in order.
  always_comb begin
    alu_ack_c    = '0;
    mult_ack_c   = '0;
    lane_nxt     = '0;
    alu_ptr_nxt  = alu_ptr;
    mult_ptr_nxt = mult_ptr;
    used         = 0;
    idx          = 0;
    alu_pri      = (starve_cnt == SW'(STARVE_LIMIT));
    if (rst_n && !flush) begin
      for (int unsigned pass = 0; pass < 2; pass++) begin
        if ((pass == 0) == alu_pri) begin
          for (int unsigned i = 0; i < N_ALU_CMP; i++) begin
            idx = 32'(alu_ptr) + i;
            if (idx >= N_ALU_CMP) idx = idx - N_ALU_CMP;
            if (alu_cmp_done[AW'(idx)] && used < N_CDB) begin
              alu_ack_c[AW'(idx)] = 1'b1;
              lane_nxt[LW'(used)] = from_fu(alu_cmp_output_data[AW'(idx)], 1'b1);
              alu_ptr_nxt         = (idx == N_ALU_CMP - 1) ? '0 : AW'(idx + 1);
              used                = used + 1;
            end
          end
        end else begin
          for (int unsigned i = 0; i < N_MULT; i++) begin
            idx = 32'(mult_ptr) + i;
            if (idx >= N_MULT) idx = idx - N_MULT;
            if (mult_done[MW'(idx)] && used < N_CDB) begin
              mult_ack_c[MW'(idx)] = 1'b1;
              lane_nxt[LW'(used)]  = from_fu(mult_output_data[MW'(idx)], 1'b0);
              mult_ptr_nxt         = (idx == N_MULT - 1) ? '0 : MW'(idx + 1);
              used                 = used + 1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    if (flush || (alu_ack_c != '0) || (alu_cmp_done == '0)) begin
      starve_nxt = '0;
    end else if (starve_cnt == SW'(STARVE_LIMIT)) begin
      starve_nxt = starve_cnt;
    end else begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  assign alu_cmp_ack = alu_ack_c;
  assign mult_ack    = mult_ack_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ptr    <= '0;
      mult_ptr   <= '0;
      starve_cnt <= '0;
      cdb        <= '0;
    end else begin
      alu_ptr    <= alu_ptr_nxt;
      mult_ptr   <= mult_ptr_nxt;
      starve_cnt <= starve_nxt;
      cdb        <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_ss_cdb_arbiter_rr.sv
// Randomized scoreboard bench for ss_cdb_arbiter_rr: a queue-based reference model predicts
// acks and the registered broadcast; a monitor compares every cdb lane one cycle later.

module tb_ss_cdb_arbiter_rr;
  import rv32i_types::*;

  localparam int NA = 4;
  localparam int NM = 2;
  localparam int NC = 2;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic         [NA-1:0] alu_cmp_done = '0;
  fu_cdb_data_t [NA-1:0] alu_cmp_output_data = '0;
  logic         [NM-1:0] mult_done = '0;
  fu_cdb_data_t [NM-1:0] mult_output_data = '0;
  logic         [NA-1:0] alu_cmp_ack;
  logic         [NM-1:0] mult_ack;
  cdb_t         [NC-1:0] cdb;

  always #5 clk = ~clk;

  ss_cdb_arbiter_rr #(
    .N_ALU_CMP(NA),
    .N_MULT(NM),
    .N_CDB(NC),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .alu_cmp_done(alu_cmp_done),
    .alu_cmp_output_data(alu_cmp_output_data),
    .mult_done(mult_done),
    .mult_output_data(mult_output_data),
    .alu_cmp_ack(alu_cmp_ack),
    .mult_ack(mult_ack),
    .cdb(cdb)
  );

  int checks = 0;
  int errors = 0;

  cdb_t exp_q[$];
  int   lane_q[$];

  logic         alu_pend[NA];
  fu_cdb_data_t alu_dat[NA];
  logic         mult_pend[NM];
  fu_cdb_data_t mult_dat[NM];
  int alu_rate = 0;
  int mult_rate = 0;

  int m_alu_ptr = 0;
  int m_mult_ptr = 0;
  int m_starve = 0;

  logic [NA-1:0] dut_alu_ack;
  logic [NM-1:0] dut_mult_ack;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fu_cdb_data_t rand_fu();
    fu_cdb_data_t d;
    d.pd_s           = 6'($urandom);
    d.rob_num        = 5'($urandom);
    d.pd_v           = $urandom;
    d.rvfi_data.pc   = $urandom;
    d.rvfi_data.inst = $urandom;
    d.br_en          = 1'($urandom);
    d.br_target      = $urandom;
    return d;
  endfunction

  function automatic cdb_t expect_lane(fu_cdb_data_t d, bit is_alu);
    cdb_t c;
    c           = '0;
    c.valid     = 1'b1;
    c.pd_s      = d.pd_s;
    c.rob_num   = d.rob_num;
    c.pd_v      = d.pd_v;
    c.rvfi_data = d.rvfi_data;
    if (is_alu) begin
      c.br_en     = d.br_en;
      c.branch_pc = d.br_target;
    end
    return c;
  endfunction

  function automatic bit any_pending();
    bit a;
    a = 0;
    for (int i = 0; i < NA; i++) a |= alu_pend[i];
    for (int i = 0; i < NM; i++) a |= mult_pend[i];
    return a;
  endfunction

  // One arbitration cycle: FUs present requests, the model builds the ordered request
  // list for this cycle, the first NC entries win.
  task automatic step(input bit fl);
    int  req_cls[$];
    int  req_idx[$];
    bit  alu_first;
    bit  take_alu;
    int  n;
    int  ptr;
    int  u;
    bit  any_alu_req;
    bit  any_alu_gnt;
    logic [NA-1:0] ea;
    logic [NM-1:0] em;
    @(negedge clk);
    for (int i = 0; i < NA; i++)
      if (!alu_pend[i] && $urandom_range(99) < alu_rate) begin
        alu_pend[i] = 1'b1;
        alu_dat[i]  = rand_fu();
      end
    for (int i = 0; i < NM; i++)
      if (!mult_pend[i] && $urandom_range(99) < mult_rate) begin
        mult_pend[i] = 1'b1;
        mult_dat[i]  = rand_fu();
      end
    for (int i = 0; i < NA; i++) begin
      alu_cmp_done[i]        = alu_pend[i];
      alu_cmp_output_data[i] = alu_pend[i] ? alu_dat[i] : rand_fu();
    end
    for (int i = 0; i < NM; i++) begin
      mult_done[i]        = mult_pend[i];
      mult_output_data[i] = mult_pend[i] ? mult_dat[i] : rand_fu();
    end
    flush = fl;
    #1;
    ea = '0;
    em = '0;
    any_alu_req = 0;
    any_alu_gnt = 0;
    for (int i = 0; i < NA; i++) any_alu_req |= alu_pend[i];
    if (!fl) begin
      alu_first = (m_starve == SL);
      for (int p = 0; p < 2; p++) begin
        take_alu = ((p == 0) == alu_first);
        n   = take_alu ? NA : NM;
        ptr = take_alu ? m_alu_ptr : m_mult_ptr;
        for (int k = 0; k < n; k++) begin
          u = (ptr + k) % n;
          if (take_alu ? alu_pend[u] : mult_pend[u]) begin
            req_cls.push_back(int'(take_alu));
            req_idx.push_back(u);
          end
        end
      end
      for (int j = 0; j < req_idx.size() && j < NC; j++) begin
        u = req_idx[j];
        lane_q.push_back(j);
        if (req_cls[j] == 1) begin
          ea[u] = 1'b1;
          any_alu_gnt = 1;
          exp_q.push_back(expect_lane(alu_dat[u], 1));
          m_alu_ptr = (u + 1) % NA;
        end else begin
          em[u] = 1'b1;
          exp_q.push_back(expect_lane(mult_dat[u], 0));
          m_mult_ptr = (u + 1) % NM;
        end
      end
    end
    if (fl || any_alu_gnt || !any_alu_req) m_starve = 0;
    else if (m_starve < SL) m_starve++;
    dut_alu_ack  = alu_cmp_ack;
    dut_mult_ack = mult_ack;
    check("ack", {alu_cmp_ack, mult_ack}, {ea, em});
    for (int i = 0; i < NA; i++) if (ea[i]) alu_pend[i] = 1'b0;
    for (int i = 0; i < NM; i++) if (em[i]) mult_pend[i] = 1'b0;
  endtask

  task automatic model_reset();
    m_alu_ptr  = 0;
    m_mult_ptr = 0;
    m_starve   = 0;
    exp_q.delete();
    lane_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    alu_rate  = 0;
    mult_rate = 0;
    for (int i = 0; i < 20 && any_pending(); i++) step(0);
    check("drain", any_pending(), 0);
  endtask

  // Monitor: every valid lane must match the next scoreboard entry; idle lanes are all-zero.
  initial begin
    cdb_t e;
    int   l;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        if (cdb[k].valid) begin
          if (exp_q.size() == 0) begin
            check("cdb_unexpected", cdb[k], '0);
          end else begin
            e = exp_q.pop_front();
            l = lane_q.pop_front();
            check("cdb_lane", {8'(k), cdb[k]}, {8'(l), e});
          end
        end else begin
          check("cdb_idle", cdb[k], '0);
        end
      end
      check("cdb_missing", exp_q.size(), 0);
      exp_q.delete();
      lane_q.delete();
    end
  end

  initial begin
    for (int i = 0; i < NA; i++) begin alu_pend[i] = 1'b0; alu_dat[i] = '0; end
    for (int i = 0; i < NM; i++) begin mult_pend[i] = 1'b0; mult_dat[i] = '0; end
    dut_alu_ack  = '0;
    dut_mult_ack = '0;

    // Reset and idle
    #3;
    check("reset_acks", {alu_cmp_ack, mult_ack}, '0);
    check("reset_cdb", cdb, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0);
    step(0);

    // Under-subscription: MULT0 and ALU2 both acked, MULT on lane 0
    mult_pend[0] = 1'b1; mult_dat[0] = rand_fu();
    alu_pend[2]  = 1'b1; alu_dat[2]  = rand_fu();
    step(0);
    check("undersub_mult_ack", dut_mult_ack, 2'b01);
    check("undersub_alu_ack", dut_alu_ack, 4'b0100);
    step(0);

    // Round-robin fairness with all ALUs continuously requesting
    drain();
    do_reset();
    alu_rate = 100;
    step(0); check("rr_0", dut_alu_ack, 4'b0011);
    step(0); check("rr_1", dut_alu_ack, 4'b1100);
    step(0); check("rr_2", dut_alu_ack, 4'b0011);

    // Starvation override: ALU0 waits four cycles behind both MULTs
    drain();
    do_reset();
    mult_rate   = 100;
    alu_pend[0] = 1'b1; alu_dat[0] = rand_fu();
    for (int c = 0; c < 5; c++) begin
      step(0);
      if (c < 4) check("starve_wait", dut_alu_ack, 4'b0000);
      else begin
        check("starve_alu_ack", dut_alu_ack, 4'b0001);
        check("starve_mult_cnt", $countones(dut_mult_ack), 1);
      end
    end

    // Flush blocks the ack; the held request is granted the following cycle
    drain();
    alu_pend[1] = 1'b1; alu_dat[1] = rand_fu();
    step(1);
    check("flush_ack", {dut_alu_ack, dut_mult_ack}, '0);
    step(0);
    check("post_flush_ack", dut_alu_ack, 4'b0010);
    step(0);

    // Async reset mid-burst clears the broadcast at once and the pointers
    drain();
    do_reset();
    alu_rate = 100;
    step(0);
    @(posedge clk);
    #2;
    check("burst_valid", cdb[0].valid, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_valid", cdb[0].valid, 1'b0);
    check("async_acks", {alu_cmp_ack, mult_ack}, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0);
    check("regrant_from_0", dut_alu_ack, 4'b0011);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        alu_rate  = $urandom_range(100);
        mult_rate = $urandom_range(100);
      end
      step($urandom_range(9) == 0);
    end

    drain();
    step(0);
    step(0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
